// File: rtl/instruction_decoder_if.sv
// Memory-port and datapath-control bundle between the SimpleCISC sequencer and its peers.
//   master: the sequencer (instruction_decoder): drives the memory request and datapath strobes.
//   slave : the memory/datapath side: returns read data, the ready handshake and the Z flag.
interface instruction_decoder_if;
  localparam int unsigned WORD_W = 16;

  // memory side
  logic [WORD_W-1:0] mem_rdata;
  logic              mem_ready;
  logic              mem_req;
  logic              mem_we;
  logic [1:0]        addr_sel;
  // datapath side
  logic              z;
  logic              pc_inc;
  logic              pc_load;
  logic [WORD_W-1:0] operand;
  logic [1:0]        src_sel;
  logic [1:0]        dst_sel;
  logic [3:0]        alu_fn;
  logic [1:0]        b_sel;
  logic              reg_we;
  logic              instr_done;
  logic              illegal;

  modport master (
    input  mem_rdata, mem_ready, z,
    output mem_req, mem_we, addr_sel, pc_inc, pc_load, operand,
           src_sel, dst_sel, alu_fn, b_sel, reg_we, instr_done, illegal
  );

  modport slave (
    output mem_rdata, mem_ready, z,
    input  mem_req, mem_we, addr_sel, pc_inc, pc_load, operand,
           src_sel, dst_sel, alu_fn, b_sel, reg_we, instr_done, illegal
  );
endinterface

// File: rtl/instruction_decoder.sv
// SimpleCISC multi-cycle control sequencer: fetches an instruction word, decodes mode/class/fields,
// fetches the operand word when the mode needs one and drives memory and datapath strobes.
// Ports:
//   clk  - system clock, rising edge
//   rst  - synchronous active-high reset; all outputs forced to 0 while high
//   bus  - instruction_decoder_if.master: mem_rdata/mem_ready/z in; mem_req, mem_we, addr_sel,
//          pc_inc, pc_load, operand, src_sel, dst_sel, alu_fn, b_sel, reg_we, instr_done, illegal out
// State, IR, operand and the sticky illegal flag are registered. The per-cycle strobes are decoded
// from the registered state plus mem_ready, because they must coincide with the completing access.
module instruction_decoder (
  input  logic                  clk,
  input  logic                  rst,
  instruction_decoder_if.master bus
);

  localparam int unsigned WORD_W = 16;
  localparam int unsigned FLD_W  = 4;
  localparam int unsigned SEL_W  = 2;

  localparam logic [FLD_W-1:0] MODE_INH = 4'd0;
  localparam logic [FLD_W-1:0] MODE_PCR = 4'd1;
  localparam logic [FLD_W-1:0] MODE_IMM = 4'd2;
  localparam logic [FLD_W-1:0] MODE_DIR = 4'd3;
  localparam logic [FLD_W-1:0] MODE_IDX = 4'd4;

  localparam logic [FLD_W-1:0] CLS_LOAD  = 4'd0;
  localparam logic [FLD_W-1:0] CLS_STORE = 4'd1;
  localparam logic [FLD_W-1:0] CLS_ALU   = 4'd2;
  localparam logic [FLD_W-1:0] CLS_CTRL  = 4'd3;

  localparam logic [FLD_W-1:0] FN_REG    = 4'd0;
  localparam logic [FLD_W-1:0] FN_MEM    = 4'd8;
  localparam logic [FLD_W-1:0] FN_UN_LO  = 4'd1;  // NOT
  localparam logic [FLD_W-1:0] FN_UN_HI  = 4'd3;  // LSR
  localparam logic [FLD_W-1:0] FN_BIN_LO = 4'd4;  // ADD
  localparam logic [FLD_W-1:0] FN_BIN_HI = 4'd7;  // OR

  localparam logic [SEL_W-1:0] REG_ACC    = 2'd0;
  localparam logic [SEL_W-1:0] ASEL_PC    = 2'd0;
  localparam logic [SEL_W-1:0] ASEL_OP    = 2'd1;
  localparam logic [SEL_W-1:0] ASEL_OPX   = 2'd2;
  localparam logic [SEL_W-1:0] ASEL_PCREL = 2'd3;
  localparam logic [SEL_W-1:0] BSEL_REG   = 2'd0;
  localparam logic [SEL_W-1:0] BSEL_MEM   = 2'd1;
  localparam logic [SEL_W-1:0] BSEL_OPND  = 2'd2;

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_OPERAND, S_MEM, S_EXEC, S_TRAP
  } state_t;

  state_t             state;
  logic [WORD_W-1:0]  ir;
  logic [WORD_W-1:0]  operand_q;
  logic               illegal_q;

  logic [FLD_W-1:0]   mode, cls, fn;
  logic [SEL_W-1:0]   src, dst;
  logic               mode_opnd;   // IMMEDIATE, DIRECT or INDEXED
  logic               mode_mem;    // DIRECT or INDEXED
  logic               legal;
  logic               cond_true;

  logic               mem_req_c, mem_we_c, pc_inc_c, pc_load_c, reg_we_c, instr_done_c;
  logic [SEL_W-1:0]   addr_sel_c, b_sel_c;

  assign mode = ir[15:12];
  assign cls  = ir[11:8];
  assign src  = ir[7:6];
  assign dst  = ir[5:4];
  assign fn   = ir[3:0];

  assign mode_mem  = (mode == MODE_DIR) || (mode == MODE_IDX);
  assign mode_opnd = (mode == MODE_IMM) || mode_mem;

  // Legal class/mode/function combinations; anything not listed traps.
  always_comb begin
    legal = 1'b0;
    case (cls)
      CLS_LOAD: begin
        if (fn == FN_MEM)      legal = mode_opnd;
        else if (fn == FN_REG) legal = (mode == MODE_INH) && (src == REG_ACC) && (dst == REG_ACC);
      end
      CLS_STORE: legal = mode_mem && (fn == FN_REG);
      CLS_ALU: begin
        if (fn >= FN_UN_LO && fn <= FN_UN_HI)        legal = (mode == MODE_INH);
        else if (fn >= FN_BIN_LO && fn <= FN_BIN_HI) legal = mode_opnd;
      end
      CLS_CTRL:  legal = (mode == MODE_PCR) && (fn[3:2] == 2'b00);
      default:   legal = 1'b0;
    endcase
  end

  // Branch condition: 0 never, 1 always, 2 taken when Z=0, 3 taken when Z=1.
  always_comb begin
    cond_true = 1'b0;
    case (fn[1:0])
      2'd0:    cond_true = 1'b0;
      2'd1:    cond_true = 1'b1;
      2'd2:    cond_true = ~bus.z;
      default: cond_true = bus.z;
    endcase
  end

  // Sequencer state, instruction and operand registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_FETCH;
      ir        <= '0;
      operand_q <= '0;
      illegal_q <= 1'b0;
    end else begin
      case (state)
        S_FETCH: begin
          if (bus.mem_ready) begin
            ir    <= bus.mem_rdata;
            state <= S_DECODE;
          end
        end
        S_DECODE: begin
          if (!legal) begin
            illegal_q <= 1'b1;
            state     <= S_TRAP;
          end else if (mode == MODE_INH) begin
            state <= S_EXEC;
          end else begin
            state <= S_OPERAND;
          end
        end
        S_OPERAND: begin
          if (bus.mem_ready) begin
            operand_q <= bus.mem_rdata;
            state     <= mode_mem ? S_MEM : S_EXEC;
          end
        end
        S_MEM: begin
          if (bus.mem_ready) state <= S_FETCH;
        end
        S_EXEC:  state <= S_FETCH;
        S_TRAP:  state <= S_TRAP;
        default: state <= S_FETCH;
      endcase
    end
  end

  // Per-cycle strobe decode from the current state.
  always_comb begin
    mem_req_c    = 1'b0;
    mem_we_c     = 1'b0;
    addr_sel_c   = ASEL_PC;
    pc_inc_c     = 1'b0;
    pc_load_c    = 1'b0;
    b_sel_c      = BSEL_REG;
    reg_we_c     = 1'b0;
    instr_done_c = 1'b0;
    case (state)
      S_FETCH, S_OPERAND: begin
        mem_req_c = 1'b1;
        pc_inc_c  = bus.mem_ready;
      end
      S_MEM: begin
        mem_req_c    = 1'b1;
        addr_sel_c   = (mode == MODE_IDX) ? ASEL_OPX : ASEL_OP;
        instr_done_c = bus.mem_ready;
        if (cls == CLS_STORE) begin
          mem_we_c = 1'b1;
        end else begin
          b_sel_c  = BSEL_MEM;
          reg_we_c = bus.mem_ready;
        end
      end
      S_EXEC: begin
        instr_done_c = 1'b1;
        if (cls == CLS_CTRL) begin
          addr_sel_c = ASEL_PCREL;
          pc_load_c  = cond_true;
        end else if (mode == MODE_IMM) begin
          reg_we_c = 1'b1;
          b_sel_c  = BSEL_OPND;
        end else if (cls == CLS_ALU) begin
          reg_we_c = 1'b1;   // unary ALU on the register file
        end
        // load INHERENT is the NOP: no strobes
      end
      default: ;
    endcase
  end

  // Reset forces every output low, so nothing partial leaks out once reset rises.
  assign bus.mem_req    = ~rst & mem_req_c;
  assign bus.mem_we     = ~rst & mem_we_c;
  assign bus.addr_sel   = rst ? ASEL_PC : addr_sel_c;
  assign bus.pc_inc     = ~rst & pc_inc_c;
  assign bus.pc_load    = ~rst & pc_load_c;
  assign bus.operand    = rst ? '0 : operand_q;
  assign bus.src_sel    = rst ? REG_ACC : src;
  assign bus.dst_sel    = rst ? REG_ACC : dst;
  assign bus.alu_fn     = (rst || cls != CLS_ALU) ? FN_REG : fn;
  assign bus.b_sel      = rst ? BSEL_REG : b_sel_c;
  assign bus.reg_we     = ~rst & reg_we_c;
  assign bus.instr_done = ~rst & instr_done_c;
  assign bus.illegal    = ~rst & illegal_q;

endmodule

// File: doc/instruction_decoder.md
# instruction_decoder

Multi-cycle control sequencer for the SimpleCISC core. It fetches 16-bit instruction words, decodes the opcode-package encoding (class, source, destination and function/condition fields, plus addressing mode), fetches the operand word when needed and drives the datapath and memory control strobes. It sits between the unified memory port and the accumulator/X/S/PC datapath; the opcode package defines the encoding and this block consumes it.

## Interface
- No parameters; data and instruction word width is fixed at 16.
- Clock  in  1  system clock; all state changes on rising edge.
- Reset  in  1  synchronous, active-high reset.
- mem_rdata  in  16  read data, valid when mem_ready=1.
- mem_ready  in  1  access complete; sampled on the edge while mem_req=1.
- Z  in  1  datapath zero flag, sampled in EXEC.
- mem_req  out  1  memory access request, held until mem_ready.
- mem_we  out  1  write strobe, qualified by mem_req.
- addr_sel  out  2  address source: 0=PC, 1=operand, 2=operand+X, 3=PC+operand.
- pc_inc  out  1  PC+1 this edge.
- pc_load  out  1  PC<=PC+operand this edge.
- operand  out  16  registered operand word.
- src_sel, dst_sel  out  2 each  register selects (0=ACC, 1=X, 2=S, 3=PC), from IR[7:6] and IR[5:4].
- alu_fn  out  4  IR[3:0] for ALU class; FnReg otherwise.
- b_sel  out  2  ALU B / write-data source: 0=register, 1=mem_rdata, 2=operand.
- reg_we  out  1  write dst_sel register this edge.
- instr_done  out  1  one-cycle pulse on the last cycle of each instruction.
- illegal  out  1  sticky; set on illegal decode, cleared only by Reset.

## Operation
- Word format: [15:12] mode (0 INHERENT, 1 PC_RELATIVE, 2 IMMEDIATE, 3 DIRECT, 4 INDEXED), [11:8] class, [7:6] src, [5:4] dst, [3:0] fn/condition.
- States: FETCH, DECODE, OPERAND, MEM, EXEC, TRAP.
- FETCH: mem_req=1, addr_sel=0. On mem_ready: IR<=mem_rdata, pc_inc=1, go to DECODE.
- DECODE (always 1 cycle): illegal leads to TRAP with illegal<=1. INHERENT leads to EXEC. Any other mode leads to OPERAND.
- OPERAND: mem_req=1, addr_sel=0. On mem_ready: operand<=mem_rdata, pc_inc=1. DIRECT or INDEXED lead to MEM; otherwise EXEC.
- MEM: mem_req=1, addr_sel=1 for DIRECT or 2 for INDEXED. Store: mem_we=1, b_sel=0. Load and ALU: b_sel=1 and reg_we=1 on the mem_ready edge. On mem_ready: instr_done=1, go to FETCH.
- EXEC (1 cycle), then instr_done=1 and go to FETCH:
  - load IMMEDIATE: reg_we=1, b_sel=2.
  - NOP: no strobes.
  - unary ALU: reg_we=1.
  - binary ALU IMMEDIATE: reg_we=1, b_sel=2.
  - branch: pc_load=1 if condition holds (Never=0, Always=1, Zequal0 when Z=0, Zequal1 when Z=1); addr_sel=3.
- Legal decodes; everything else is illegal:
  - load, fn=FnMem: modes IMMEDIATE, DIRECT or INDEXED.
  - load, fn=FnReg: INHERENT with src=dst=ACC (NOP) only.
  - store: modes DIRECT or INDEXED only, fn=FnReg.
  - ALU, fn NOT, LSL or LSR: INHERENT only.
  - ALU, fn ADD, SUB, AND or OR: IMMEDIATE, DIRECT or INDEXED.
  - control transfer: PC_RELATIVE only, condition 0-3.
  - Also illegal: class 4 or higher, mode 5 or higher, ALU fn 0 or 8 or higher.
- TRAP: all strobes 0, no further fetch, remains until Reset.

## Timing
- Reset: state<=FETCH, IR<=0, operand<=0, illegal<=0.
- While Reset=1, every output is 0. The first cycle after release is FETCH with mem_req=1.
- mem_ready may be high in the first request cycle, which gives a 1-cycle access. mem_req and address stay stable until the mem_ready edge.
- Zero-wait latencies, FETCH entry to instr_done:
  - INHERENT: 3 cycles.
  - IMMEDIATE or PC_RELATIVE: 4 cycles.
  - DIRECT or INDEXED: 4 cycles.
- Each wait cycle adds one cycle.
- mem_ready while mem_req=0 is ignored.
- Reset mid-instruction abandons the instruction. No partial reg_we or pc_load is issued after Reset rises.
- PC+operand and operand+X are 16-bit wraparound (datapath adds); this block only selects.

## Test plan
- Reset, then 0x0000 (NOP) with zero-wait memory: pc_inc pulses once, instr_done at cycle 3, no reg_we or mem_we.
- 0x2008 (LDA IMMEDIATE), operand 0x1234: operand=0x1234, reg_we=1 with b_sel=2, dst_sel=0, instr_done at cycle 4.
- 0x3204 (ADD DIRECT), operand 0x0040, 2 wait states on each access: MEM has addr_sel=1, and reg_we, b_sel=1 and alu_fn=4 coincide with mem_ready; total 10 cycles.
- 0x4150 (STX INDEXED): MEM drives mem_we=1, addr_sel=2, src_sel=1; reg_we stays 0.
- 0x13F3 (BEQ) with Z=1, then repeat with Z=0: first run gives pc_load=1 with addr_sel=3; second gives pc_load=0; both give instr_done.
- 0x0500 (class 5): illegal=1 after DECODE and no further mem_req. Reset asserted mid-OPERAND of the next program restarts in FETCH with illegal=0.
